// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the R-channel beat payload used by the read responder.
package axi_pkg;

    localparam int unsigned AXI_DATA_W = 32;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } r_beat_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/r_skid_fifo.sv
// Two-entry FIFO holding R beats; head entry drives the R channel directly.
module r_skid_fifo
    import axi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  r_beat_t    push_beat,
    input  logic       pop,
    output r_beat_t    head,
    output logic       head_valid,
    output logic [1:0] occ
);

    r_beat_t    mem_q [2];
    r_beat_t    mem_d [2];
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] cnt_q, cnt_d;
    logic       do_push;
    logic       do_pop;

    always_comb begin
        do_pop  = pop && (cnt_q != 2'd0);
        do_push = push && ((cnt_q != 2'd2) || do_pop);
        mem_d   = mem_q;
        wr_d    = wr_q ^ do_push;
        rd_d    = rd_q ^ do_pop;
        cnt_d   = cnt_q + 2'(do_push) - 2'(do_pop);
        if (do_push) begin
            mem_d[wr_q] = push_beat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head       = mem_q[rd_q];
    assign head_valid = (cnt_q != 2'd0);
    assign occ        = cnt_q;

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read slave: walks FIXED/INCR/WRAP bursts over a 1-cycle SRAM and returns
// beats through a 2-entry buffer, one beat per cycle when the master is ready.
module axi_rd_responder
    import axi_pkg::*;
#(
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  mem_en,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic [AXI_DATA_W-1:0] mem_rdata
);

    typedef enum logic {S_IDLE, S_BURST} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic              err_q, err_d;
    logic [8:0]        left_q, left_d;
    logic              fl_q, fl_d;
    logic              fl_err_q, fl_err_d;
    logic              fl_last_q, fl_last_d;

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] next_addr;
    logic              ar_err;
    logic              pop;
    logic              issue;
    logic [1:0]        occ;
    logic [2:0]        pending;
    logic              head_valid;
    r_beat_t           head;
    r_beat_t           push_beat;

    // Burst address generator.
    always_comb begin
        step      = ADDR_W'(1) << size_q;
        wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
        case (burst_q)
            BURST_INCR: next_addr = addr_q + step;
            BURST_WRAP: next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default:    next_addr = addr_q;
        endcase
    end

    assign ar_err = (arsize > 3'd2) || (arburst == BURST_RSVD) ||
                    ((arburst == BURST_WRAP) && !wrap_len_ok(arlen));

    // A slot is reserved in the buffer for every read in flight, so issuing is
    // gated on buffered + in-flight beats (net of this cycle's pop) staying below 2.
    assign pop     = head_valid && rready;
    assign pending = 3'(occ) + 3'(fl_q) - 3'(pop);
    assign issue   = (state_q == S_BURST) && (left_q != 9'd0) && (pending < 3'd2);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        err_d     = err_q;
        left_d    = left_q;
        fl_d      = issue;
        fl_err_d  = err_q;
        fl_last_d = (left_q == 9'd1);
        case (state_q)
            S_IDLE: begin
                if (arvalid) begin
                    addr_d  = araddr;
                    len_d   = arlen;
                    size_d  = arsize;
                    burst_d = arburst;
                    err_d   = ar_err;
                    left_d  = 9'(arlen) + 9'd1;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (issue) begin
                    left_d = left_q - 9'd1;
                    addr_d = next_addr;
                end
                if (pop && head.last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'd0;
            err_q     <= 1'b0;
            left_q    <= 9'd0;
            fl_q      <= 1'b0;
            fl_err_q  <= 1'b0;
            fl_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            left_q    <= left_d;
            fl_q      <= fl_d;
            fl_err_q  <= fl_err_d;
            fl_last_q <= fl_last_d;
        end
    end

    // Error slots follow the same pipeline as reads but carry zero data.
    always_comb begin
        push_beat.data = fl_err_q ? '0 : mem_rdata;
        push_beat.resp = fl_err_q ? RESP_SLVERR : RESP_OKAY;
        push_beat.last = fl_last_q;
    end

    r_skid_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fl_q),
        .push_beat  (push_beat),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .occ        (occ)
    );

    assign arready  = (state_q == S_IDLE);
    assign mem_en   = issue && !err_q;
    assign mem_addr = addr_q[MEM_AW+1:2];
    assign rdata    = head.data;
    assign rresp    = head.resp;
    assign rlast    = head.last;
    assign rvalid   = head_valid;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Scoreboard bench for axi_rd_responder: directed bursts, SRAM model, R-channel monitor.
module tb_axi_rd_responder;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = 32'd0;

    int n_checks = 0;
    int n_errors = 0;

    r_beat_t  exp_q[$];
    int       exp_ma[$];

    // Monitor state
    int       n_iss = 0;
    int       n_pop = 0;
    int       n_beats = 0;
    bit       stall_prev = 0;
    bit       last_hs_prev = 0;
    r_beat_t  prev_beat;

    axi_rd_responder dut (
        .clk       (clk),
        .rst       (rst),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_val(input int w);
        return 32'hC0DE_0000 ^ (32'(w) * 32'h0001_0003);
    endfunction

    // Synchronous SRAM model, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= word_val(int'(mem_addr));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: address sequence, R beats, stall stability, overrun and arready return.
    always @(negedge clk) begin
        r_beat_t cur;
        r_beat_t e;
        bit      hs;
        int      ma;
        if (rst) begin
            n_iss = 0;
            n_pop = 0;
            stall_prev = 0;
            last_hs_prev = 0;
        end else begin
            hs = rvalid && rready;
            cur.data = rdata;
            cur.resp = rresp;
            cur.last = rlast;
            if (mem_en) begin
                if (exp_ma.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL mem_en_unexpected: got mem_addr 0x%0h expected no read", mem_addr);
                end else begin
                    ma = exp_ma.pop_front();
                    chk("mem_addr", 64'(mem_addr), 64'(ma));
                end
                chk("no_overrun", 64'((n_iss + 1 - n_pop - int'(hs)) > 2), 64'd0);
                n_iss++;
            end
            if (stall_prev) begin
                chk("stall_rvalid", 64'(rvalid), 64'd1);
                chk("stall_beat", 64'(cur), 64'(prev_beat));
            end
            if (last_hs_prev) chk("arready_after_last", 64'(arready), 64'd1);
            if (hs) begin
                n_pop++;
                n_beats++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL r_beat_unexpected: got 0x%0h expected no beat", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("r_beat", 64'(cur), 64'(e));
                end
            end
            stall_prev   = rvalid && !rready;
            prev_beat    = cur;
            last_hs_prev = hs && rlast;
            if (arready && !rvalid) begin
                n_iss = 0;
                n_pop = 0;
            end
        end
    end

    task automatic push_ok(input int w, input bit last);
        r_beat_t b;
        b.data = word_val(w);
        b.resp = RESP_OKAY;
        b.last = last;
        exp_q.push_back(b);
        exp_ma.push_back(w);
    endtask

    task automatic push_err(input int n);
        r_beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = 32'd0;
            b.resp = RESP_SLVERR;
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b);
        int k;
        araddr  = a;
        arlen   = l;
        arsize  = s;
        arburst = b;
        arvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!arready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("ar_accept", 64'(arready), 64'd1);
        @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    // Waits for the scoreboard to drain and arready to return; optionally toggles rready.
    task automatic wait_done(input bit toggle);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !arready) && k < 400) begin
            @(posedge clk);
            #1;
            if (toggle) rready = ~rready;
            k++;
        end
        chk("burst_done_in_time", 64'(k < 400), 64'd1);
        chk("all_reads_seen", 64'(exp_ma.size()), 64'd0);
        rready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int base;
        int k;
        rst     = 1'b1;
        araddr  = 32'd0;
        arlen   = 8'd0;
        arsize  = 3'd0;
        arburst = 2'd0;
        arvalid = 1'b0;
        rready  = 1'b1;
        #12;
        chk("reset_arready", 64'(arready), 64'd1);
        chk("reset_rvalid", 64'(rvalid), 64'd0);
        chk("reset_rlast", 64'(rlast), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        chk("reset_rresp", 64'(rresp), 64'd0);
        chk("reset_mem_en", 64'(mem_en), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // INCR 4 beats from 0x10: words 4..7, latency and back-to-back beats
        push_ok(4, 0); push_ok(5, 0); push_ok(6, 0); push_ok(7, 1);
        send_ar(32'h10, 8'd3, 3'd2, BURST_INCR);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rvalid && lat < 20);
        chk("first_beat_latency", 64'(lat), 64'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_bubble", 64'(rvalid), 64'd1);
        end
        wait_done(1'b0);

        // WRAP 4 beats from 0x18: words 6,7,4,5
        push_ok(6, 0); push_ok(7, 0); push_ok(4, 0); push_ok(5, 1);
        send_ar(32'h18, 8'd3, 3'd2, BURST_WRAP);
        wait_done(1'b0);

        // FIXED 3 beats at 0x8: word 2 three times
        push_ok(2, 0); push_ok(2, 0); push_ok(2, 1);
        send_ar(32'h8, 8'd2, 3'd2, BURST_FIXED);
        wait_done(1'b0);

        // INCR 8 beats from 0x100 with rready toggling 1,0,1,0
        for (int i = 0; i < 8; i++) push_ok(64 + i, i == 7);
        send_ar(32'h100, 8'd7, 3'd2, BURST_INCR);
        wait_done(1'b1);

        // Error bursts: oversize, reserved burst type, illegal WRAP length
        push_err(3);
        send_ar(32'h0, 8'd2, 3'd3, BURST_INCR);
        wait_done(1'b0);
        push_err(2);
        send_ar(32'h20, 8'd1, 3'd2, BURST_RSVD);
        wait_done(1'b0);
        push_err(3);
        send_ar(32'h40, 8'd2, 3'd2, BURST_WRAP);
        wait_done(1'b0);

        // Reset in the middle of an 8-beat burst
        for (int i = 0; i < 8; i++) push_ok(128 + i, i == 7);
        base = n_beats;
        send_ar(32'h200, 8'd7, 3'd2, BURST_INCR);
        k = 0;
        while (n_beats < base + 2 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("two_beats_before_reset", 64'(n_beats - base), 64'd2);
        rst = 1'b1;
        exp_q.delete();
        exp_ma.delete();
        #1;
        chk("async_rst_rvalid", 64'(rvalid), 64'd0);
        chk("async_rst_arready", 64'(arready), 64'd1);
        chk("async_rst_mem_en", 64'(mem_en), 64'd0);
        chk("async_rst_rlast", 64'(rlast), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        push_ok(0, 1);
        send_ar(32'h0, 8'd0, 3'd2, BURST_INCR);
        wait_done(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_responder.md
# axi_rd_responder

AXI4 read-side slave that sits at the far end of the interconnect's R-channel router, producing one slave's `s_rdata/s_rresp/s_rlast/s_rvalid` stream. Accepts an AR request, walks the burst address sequence (FIXED/INCR/WRAP), reads a 1-cycle-latency synchronous SRAM, and returns R beats through a 2-entry buffer so backpressure never drops data. It supports full throughput: one beat per cycle while `rready` is high.

## Interface
- `MEM_AW`, 10, SRAM word-address width; depth 2^MEM_AW 32-bit words
- `ADDR_W`, 32, AXI byte-address width
- `clk` in 1 — single clock; all logic rising-edge
- `rst` in 1 — **asynchronous, active-high** reset
- `araddr` in ADDR_W — burst start byte address
- `arlen` in 8 — beats minus one
- `arsize` in 3 — log2 bytes per beat
- `arburst` in 2 — 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- `arvalid` in 1, `arready` out 1 — AR handshake
- `rdata` out 32, `rresp` out 2, `rlast` out 1, `rvalid` out 1, `rready` in 1 — R channel
- `mem_en` out 1 — SRAM read strobe
- `mem_addr` out MEM_AW — SRAM word address
- `mem_rdata` in 32 — valid the cycle after `mem_en`

## Operation
- States: IDLE, BURST. Reset → IDLE. Reset values: `arready`=1, `rvalid`=0, `rlast`=0, `rdata`=0, `rresp`=0, `mem_en`=0, `mem_addr`=0; buffer and in-flight count cleared.
- IDLE: `arready`=1. AR handshake latches addr/len/size/burst, beat counter = arlen, error flag → BURST.
- Error flag set when `arsize`>2, `arburst`=11, or WRAP with `arlen` not in {1,3,7,15}. Error bursts still return arlen+1 beats, `rdata`=0, `rresp`=10 (SLVERR), `mem_en` never asserted; same timing as normal. Otherwise `rresp`=00.
- BURST: `arready`=0. Issue a read (or error slot) when issue-count remains and (buffer occupancy − pop this cycle + in-flight) < 2. `mem_addr` = byte address bits [MEM_AW+1:2]; upper bits ignored (aliasing, no error).
- Address step inc = 1<<arsize. FIXED: unchanged. INCR: addr+inc. WRAP: boundary wb=(arlen+1)·inc; next = (addr & ~(wb−1)) | ((addr+inc) & (wb−1)).
- Narrow beats (arsize<2) return the full addressed word; the master selects lanes.
- `rlast`=1 exactly on beat arlen+1. Handshake of the `rlast` beat → IDLE.

## Timing
- AR handshake at edge E0 → `mem_en` high in cycle 1 → `mem_rdata` captured at end of cycle 2 → `rvalid` high in cycle 3 (3-cycle latency).
- With `rready` held 1: beats on consecutive cycles, no bubbles.
- `rvalid`, `rdata`, `rresp`, `rlast` stay stable while `rvalid`=1 and `rready`=0 (AXI rule); `rvalid` never deasserts without handshake.
- Buffer full and no pop: `mem_en`=0 that cycle; an in-flight read always has a free slot.
- `arready` returns to 1 the cycle after the `rlast` handshake; no AR accepted during BURST.
- `rst` asserted anytime: outputs take reset values immediately (async); in-flight beats discarded; after release, first AR accepted on the first edge with `arvalid`=1.

## Structure
- Shared `axi_pkg`: burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/EXOKAY/SLVERR/DECERR), AXI data width 32.
- Sub-module `r_skid_fifo`: 2-entry FIFO of {rdata, rresp, rlast}, with occupancy output; parent owns address generator, beat counter, FSM.

## Test plan
- INCR arlen=3 arsize=2 araddr=0x10, rready=1 → `mem_addr` 4,5,6,7; 4 consecutive OKAY beats, first `rvalid` 3 cycles after AR, `rlast` on beat 4, `arready` high next cycle.
- WRAP arlen=3 arsize=2 araddr=0x18 → `mem_addr` 6,7,4,5; data matches SRAM model.
- FIXED arlen=2 araddr=0x8 → three reads of word 2, three beats, `rlast` on third.
- INCR arlen=7, `rready` pattern 1,0,1,0… → 8 beats in order, outputs stable while stalled, never `mem_en` with buffer full and no pop.
- arsize=3 arlen=2 → 3 beats `rresp`=10 `rdata`=0, `mem_en` never high; arburst=11 same.
- `rst` pulsed after second beat of arlen=7 → `rvalid`=0 immediately, `arready`=1; subsequent INCR arlen=0 araddr=0 returns word 0 OKAY with `rlast`=1.
